hazard_scoreboard: RTL and testbench

- Sequential successor to the combinational decode controller.
- Takes the D-stage Tuse/Tnew/A3 classification from the controller and tracks in-flight destination registers through NSTAGE post-decode stages (E, M, W, …).
- Generates the pipeline stall, the D-stage forward selects, and MDU-busy interlocking with configurable multiply/divide latencies.

---
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// D-stage hazard classification bus between the decode controller (master)
// and the hazard scoreboard (slave).
interface hazard_if #(
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int SW = 2
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_read_rs;
    logic          d_read_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [AW-1:0] d_a3;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_mdft;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
               d_a3, d_tnew, d_md_start, d_md_div, d_mdft,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
               d_a3, d_tnew, d_md_start, d_md_div, d_mdft,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations through NSTAGE post-decode stages and derives stall,
// D-stage forward selects and MDU interlock. Optional HAZARD_STATS_EN adds stall counters.
module hazard_scoreboard #(
    parameter int NSTAGE  = 3,
    parameter int TW      = 2,
    parameter int AW      = 5,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    hazard_if.slave     hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
`endif
);
    localparam int SW     = $clog2(NSTAGE + 1);
    localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [AW-1:0] a3_q   [1:NSTAGE];
    logic [TW-1:0] tnew_q [1:NSTAGE];
    logic          md1_q;
    logic [CW-1:0] md_cnt_q;

    logic          data_stall;
    logic          md_stall;
    logic          stall;
    logic          issue;
    logic [SW-1:0] fwd_rs;
    logic [SW-1:0] fwd_rt;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Walk oldest to youngest so the youngest matching stage decides the select;
    // a younger match still waiting on its result masks older ready copies.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (latch).
        data_stall = 1'b0;
        fwd_rs     = '0;
        fwd_rt     = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (hz.d_valid && hz.d_read_rs && hz.d_rs != '0 && a3_q[k] == hz.d_rs) begin
                fwd_rs = (tnew_q[k] == '0) ? SW'(k) : '0;
                if (tnew_q[k] > hz.d_tuse_rs) data_stall = 1'b1;
            end
            if (hz.d_valid && hz.d_read_rt && hz.d_rt != '0 && a3_q[k] == hz.d_rt) begin
                fwd_rt = (tnew_q[k] == '0) ? SW'(k) : '0;
                if (tnew_q[k] > hz.d_tuse_rt) data_stall = 1'b1;
            end
        end
    end

    assign md_stall = hz.d_valid && hz.d_mdft && (md_cnt_q != '0 || md1_q);
    assign stall    = data_stall || md_stall;
    assign issue    = hz.d_valid && !stall;

    assign hz.stall      = stall;
    assign hz.fwd_rs_sel = fwd_rs;
    assign hz.fwd_rt_sel = fwd_rt;
    assign hz.md_busy    = (md_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: stage entries are reset too; a stale a3 would otherwise raise false stalls.
            for (int k = 1; k <= NSTAGE; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
            md1_q    <= 1'b0;
            md_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read its neighbour's old value.
            for (int k = NSTAGE; k >= 2; k--) begin
                a3_q[k]   <= a3_q[k-1];
                tnew_q[k] <= sat_dec(tnew_q[k-1]);
            end
            if (issue) begin
                a3_q[1]   <= hz.d_a3;
                tnew_q[1] <= sat_dec(hz.d_tnew);
                md1_q     <= hz.d_md_start;
            end else begin
                a3_q[1]   <= '0;
                tnew_q[1] <= '0;
                md1_q     <= 1'b0;
            end
            if (issue && hz.d_md_start)
                md_cnt_q <= hz.d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
            else if (md_cnt_q != '0)
                md_cnt_q <= md_cnt_q - CW'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall)    stall_cnt    <= stall_cnt + 32'd1;
            if (md_stall) md_stall_cnt <= md_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table plus hand-written
// MDU, reset and statistics sequences.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_if #(.AW(5), .TW(2), .SW(2)) hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] md_stall_cnt;
`endif

    hazard_scoreboard #(
        .NSTAGE(3), .TW(2), .AW(5), .MUL_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs, rt;
        logic       rrs, rrt;
        logic [1:0] urs, urt;
        logic [4:0] a3;
        logic [1:0] tn;
        logic       ms, md, mf;
        logic       e_st;
        logic [1:0] e_frs, e_frt;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input string name, input logic v, input logic [4:0] rs, rt,
                                input logic rrs, rrt, input logic [1:0] urs, urt,
                                input logic [4:0] a3, input logic [1:0] tn,
                                input logic ms, md, mf, input logic e_st,
                                input logic [1:0] e_frs, e_frt, input logic e_busy);
        vec_t r;
        r.name = name; r.v = v; r.rs = rs; r.rt = rt; r.rrs = rrs; r.rrt = rrt;
        r.urs = urs; r.urt = urt; r.a3 = a3; r.tn = tn; r.ms = ms; r.md = md; r.mf = mf;
        r.e_st = e_st; r.e_frs = e_frs; r.e_frt = e_frt; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one D-stage instruction at the falling edge and check the combinational outputs.
    task automatic step(input vec_t v);
        @(negedge clk);
        reset         = 1'b0;
        hz.d_valid    = v.v;
        hz.d_rs       = v.rs;
        hz.d_rt       = v.rt;
        hz.d_read_rs  = v.rrs;
        hz.d_read_rt  = v.rrt;
        hz.d_tuse_rs  = v.urs;
        hz.d_tuse_rt  = v.urt;
        hz.d_a3       = v.a3;
        hz.d_tnew     = v.tn;
        hz.d_md_start = v.ms;
        hz.d_md_div   = v.md;
        hz.d_mdft     = v.mf;
        #1;
        check({v.name, " stall"},   32'(hz.stall),      32'(v.e_st));
        check({v.name, " fwd_rs"},  32'(hz.fwd_rs_sel), 32'(v.e_frs));
        check({v.name, " fwd_rt"},  32'(hz.fwd_rt_sel), 32'(v.e_frt));
        check({v.name, " md_busy"}, 32'(hz.md_busy),    32'(v.e_busy));
    endtask

    //                  name   v  rs  rt rrs rrt urs urt a3 tn ms md mf  st frs frt busy
    function automatic vec_t nop(input string name, input logic e_busy);
        return mk(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_busy);
    endfunction

    task automatic div_mflo(input string tag);
        step(mk({tag, " div"}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++)
            step(mk($sformatf("%s mflo wait%0d", tag, i), 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 1, 0, 0, 1));
        step(mk({tag, " mflo go"}, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0, 0));
    endtask

    vec_t tbl[$];

    initial begin
        reset         = 1'b1;
        hz.d_valid    = 1'b0;
        hz.d_rs       = '0;
        hz.d_rt       = '0;
        hz.d_read_rs  = 1'b0;
        hz.d_read_rt  = 1'b0;
        hz.d_tuse_rs  = '0;
        hz.d_tuse_rt  = '0;
        hz.d_a3       = '0;
        hz.d_tnew     = '0;
        hz.d_md_start = 1'b0;
        hz.d_md_div   = 1'b0;
        hz.d_mdft     = 1'b0;
        repeat (2) @(posedge clk);

        //            name          v  rs  rt rrs rrt urs urt a3  tn ms md mf  st frs frt busy
        tbl.push_back(mk("reset",    0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lw8",      1, 29, 0, 1, 0, 1, 0, 8,  3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("add stl",  1, 8,  9, 1, 1, 1, 1, 10, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("add go",   1, 8,  9, 1, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("fwd3/1",   1, 8, 10, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3, 1, 0));
        tbl.push_back(mk("ori5",     1, 0, 10, 0, 1, 0, 1, 5,  2, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk("beq stl",  1, 5,  5, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("beq fwd",  1, 5,  5, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2, 2, 0));
        tbl.push_back(mk("wr r0",    1, 0,  0, 1, 1, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rd r0",    1, 0,  0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("w7 t1",    1, 0,  0, 0, 0, 0, 0, 7,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("w7 t3",    1, 7,  0, 1, 0, 0, 0, 7,  3, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("mask",     1, 7,  7, 1, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("mask stl", 1, 7,  7, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("invalid",  0, 7,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("w12 t0",   1, 0,  0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sat fwd",  1, 12, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        div_mflo("seq");

        // A multiply keeps the MDU busy for MUL_CYC cycles without blocking non-MD work.
        step(mk("mult", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) step(nop($sformatf("mult busy%0d", i), 1));
        step(nop("mult idle", 0));

        // Reset lands mid-countdown with a load in stage 1.
        step(mk("rst div", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        step(mk("rst lw8", 1, 0, 0, 0, 0, 0, 0, 8, 3, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;
        step(mk("post rst", 1, 8, 8, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("stats reset", stall_cnt, 32'd0);
        step(mk("st lw8",  1, 0, 0, 0, 0, 0, 0, 8,  3, 0, 0, 0, 0, 0, 0, 0));
        step(mk("st add",  1, 8, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0));
        step(mk("st add2", 1, 8, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        div_mflo("st");
        check("stall_cnt",    stall_cnt,    32'd11);
        check("md_stall_cnt", md_stall_cnt, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
